// File: rtl/pulse_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pulse_sequencer_pkg
//   Shared types and helpers for the pulse sequencer.
//   - state_e          : sequencer FSM state (IDLE, RUN)
//   - period_t         : widest effective-period value (MAX_N+1 bits)
//   - effective_period : maps a stored period entry to its tick count,
//                        where an entry of 0 means 2^n ticks
// -----------------------------------------------------------------------------
package pulse_sequencer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest period entry the helper supports; instances must keep N <= MAX_N.
  localparam int MAX_N = 32;

  typedef logic [MAX_N-1:0] ticks_t;
  typedef logic [MAX_N:0]   period_t;

  // One extra bit so that 2^n is representable for the "0 = full range" case.
  function automatic period_t effective_period(input ticks_t ticks, input int unsigned n);
    period_t p;
    if (ticks == '0) p = period_t'(1) << n;
    else             p = period_t'(ticks);
    return p;
  endfunction

endpackage : pulse_sequencer_pkg

// File: rtl/seq_table.sv
// -----------------------------------------------------------------------------
// seq_table
//   DEPTH x N period register file.
//   Ports:
//     clk      - clock, writes on rising edge
//     rst      - asynchronous active-low clear of every entry
//     wr_ena   - write strobe
//     wr_addr  - write index
//     wr_data  - value written
//     rd_addr  - read index
//     rd_data  - combinational read of entry rd_addr
// -----------------------------------------------------------------------------
module seq_table #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_ena,
  input  logic [CW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic [CW-1:0] rd_addr,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0] mem [DEPTH];

  // NOTE: this array is built from flops, not a RAM macro, so it can and must
  // take the asynchronous clear; an unreset entry would give an undefined
  // period on the first run after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ena) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read: a write lands at the clock edge and is visible to the
  // compare in the following cycle.
  assign rd_data = mem[rd_addr];

endmodule : seq_table

// File: rtl/pulse_sequencer.sv
// -----------------------------------------------------------------------------
// pulse_sequencer
//   Steps through a table of periods and emits a one-cycle pulse at the end of
//   each period, either once through entries 0..last_idx or repeating.
//   Ports:
//     clk         - clock
//     rst         - asynchronous active-low reset
//     ena         - tick enable; the counter advances only when high
//     wr_ena      - period-table write strobe
//     wr_addr     - period-table write index
//     wr_ticks    - period value written (0 encodes 2^N)
//     last_idx    - index of the final entry, latched at start
//     repeat_mode - wrap to entry 0 after last_idx, latched at start
//     start       - begin a sequence (ignored while running)
//     stop        - abort; wins over start and over a period match
//     busy        - high while running
//     out         - registered one-cycle pulse at each period end
//     idx         - current table entry
//     done        - registered one-cycle pulse when a one-shot run completes
// -----------------------------------------------------------------------------
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          wr_ena,
  input  logic [CW-1:0] wr_addr,
  input  logic [N-1:0]  wr_ticks,
  input  logic [CW-1:0] last_idx,
  input  logic          repeat_mode,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic          out,
  output logic [CW-1:0] idx,
  output logic          done
);

  state_e        state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] last_q, last_d;
  logic          rpt_q, rpt_d;
  logic          out_q, out_d;
  logic          done_q, done_d;

  logic [N-1:0]  rd_ticks;
  period_t       period;
  period_t       cnt_inc;
  logic          hit;

  seq_table #(
    .N     (N),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .wr_ena  (wr_ena),
    .wr_addr (wr_addr),
    .wr_data (wr_ticks),
    .rd_addr (idx_q),
    .rd_data (rd_ticks)
  );

  // Compare counter+1 against the period one bit wider than the counter so
  // that a stored 0 (2^N ticks) matches when the counter is all ones.
  assign period  = effective_period(ticks_t'(rd_ticks), N);
  assign cnt_inc = period_t'(cnt_q) + period_t'(1);
  assign hit     = (cnt_inc == period);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      rpt_q   <= 1'b0;
      out_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rpt_q   <= rpt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every signal is given its hold/default value before the case so no
  // path leaves it unassigned (which would infer a latch); blocking '=' is
  // used here because this is combinational logic, unlike the '<=' above.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    rpt_d   = rpt_q;
    out_d   = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          cnt_d   = '0;
          idx_d   = '0;
          last_d  = last_idx;
          rpt_d   = repeat_mode;
        end
      end

      RUN: begin
        if (stop) begin
          // Abort beats a match in the same cycle: no out, no done.
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (ena) begin
          if (hit) begin
            cnt_d = '0;
            out_d = 1'b1;
            if (idx_q != last_q) begin
              idx_d = idx_q + 1'b1;
            end else if (rpt_q) begin
              idx_d = '0;
            end else begin
              state_d = IDLE;
              idx_d   = '0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign out  = out_q;
  assign idx  = idx_q;
  assign done = done_q;

endmodule : pulse_sequencer
